mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Two-master arbiter for the native picorv32-style memory bus (valid/ready, addr/wdata/wstrb/rdata).
//  Master 0 is the CPU; master 1 is a DMA/debug master. One granted master drives the single slave side,
//  which feeds the existing address decoder and slave mux. A bus watchdog completes hung transfers and logs them.
// PARAMETERS
//  TIMEOUT       1024           cycles s_valid may wait for s_ready before forced completion; 0 disables watchdog
//  TIMEOUT_DATA  32'hDEAD_BEEF  rdata returned on a timed-out transfer
//  RESET_PRIO    1'b0           master holding priority after reset
// PORTS
//  clk           in   1   system clock (PLL clock domain)
//  reset         in   1   asynchronous, active-high reset
//  m0_valid      in   1   CPU request; held until m0_ready
//  m0_instr      in   1   CPU instruction-fetch flag
//  m0_addr       in   32  CPU byte address
//  m0_wdata      in   32  CPU write data
//  m0_wstrb      in   4   CPU byte strobes; 0 = read
//  m0_rdata      out  32  read data to CPU
//  m0_ready      out  1   one-cycle completion strobe to CPU
//  m1_valid/m1_addr/m1_wdata/m1_wstrb/m1_rdata/m1_ready   same as m0_*, master 1 (no instr flag)
//  s_valid       out  1   request to decoder
//  s_instr       out  1   m0_instr when owner=0, else 0
//  s_addr        out  32  owner address
//  s_wdata       out  32  owner write data
//  s_wstrb       out  4   owner strobes
//  s_rdata       in   32  data from slave mux
//  s_ready       in   1   completion from slave side
//  owner         out  1   current/last granted master
//  timeout_err   out  1   sticky: a transfer was forced complete
//  timeout_addr  out  32  s_addr of first timed-out transfer since last clear
//  err_clr       in   1   clears timeout_err/timeout_addr (err_clr wins over new timeout same cycle)
// BEHAVIOUR
//  Reset: state IDLE, owner=0, prio=RESET_PRIO, wdog=0, timeout_err=0, timeout_addr=0; all s_*, m*_ready,
//   m*_rdata = 0. Reset mid-transfer abandons it; no ready issued.
//  FSM IDLE: s_valid=0. If any m*_valid: grant = sole requester, or prio when both; owner<=grant; ->BUSY.
//  FSM BUSY: s_valid = m[owner]_valid; s_addr/s_wdata/s_wstrb/s_instr muxed combinationally from owner.
//   s_ready=1: m[owner]_ready=1 and m[owner]_rdata=s_rdata same cycle; prio<=~owner; ->IDLE.
//   wdog reaches TIMEOUT-1 with s_ready=0: m[owner]_ready=1, rdata=TIMEOUT_DATA, s_valid forced 0 that
//    cycle; timeout_err<=1; timeout_addr<=s_addr only if timeout_err was 0; prio<=~owner; ->IDLE.
//   m[owner]_valid drops before ready (abort): ->IDLE, prio unchanged, no error.
//  Latency: request in IDLE at cycle N -> s_valid at N+1; s_ready at M -> master ready at M (0 added);
//   next grant earliest M+1, s_valid again M+2. Back-to-back same master: 1 bubble cycle.
//  Non-owner m*_ready and m*_rdata are 0 at all times; s_ready in IDLE is ignored.
//  Watchdog: clog2(TIMEOUT+1)-bit counter, cleared on entry to BUSY, increments each BUSY cycle, saturates.
//   TIMEOUT=0: never fires. TIMEOUT=1: fires in first BUSY cycle unless s_ready same cycle (s_ready wins).
//  Fairness: strict alternation under continuous contention; a lone requester is never blocked by prio.
// TESTING
//  m0 alone read 0x0002_0000, s_ready 2 cycles after s_valid -> m0_ready pulse, m0_rdata=s_rdata, m1_ready=0.
//  m0,m1 valid same cycle from reset -> grants m0,m1,m0,m1...; owner toggles; 1 idle cycle between grants.
//  s_ready never asserted, TIMEOUT=16 -> m_ready at 16th BUSY cycle, rdata=0xDEADBEEF, timeout_err=1, addr latched.
//  Second timeout at other addr -> timeout_addr unchanged; err_clr pulse -> err=0, addr=0; err_clr+timeout same cycle -> 0.
//  m1 drops valid mid-BUSY -> IDLE next cycle, no ready, prio unchanged, m0 pending then granted.
//  reset asserted mid-BUSY (async, between edges) -> all outputs 0 immediately; post-release owner=0, prio=RESET_PRIO.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for a picorv32-style valid/ready memory bus, with a bus watchdog
// that force-completes hung transfers and records the first offending address.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT      = 1024,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF,
    parameter logic        RESET_PRIO   = 1'b0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,

    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,

    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    input  logic        s_ready,

    output logic        owner,
    output logic        timeout_err,
    output logic [31:0] timeout_addr,
    input  logic        err_clr
);

    // A zero TIMEOUT still needs a legal one-bit counter; the enable keeps it inert.
    localparam bit              WDOG_EN   = (TIMEOUT != 0);
    localparam int unsigned     WDOG_W    = WDOG_EN ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_EN ? WDOG_W'(TIMEOUT - 1) : '0;
    localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_EN ? WDOG_W'(TIMEOUT) : '0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              owner_next;
    logic              prio;
    logic              prio_next;
    logic [WDOG_W-1:0] wdog;
    logic [WDOG_W-1:0] wdog_next;

    logic              busy;
    logic              own_valid;
    logic              own_instr;
    logic [31:0]       own_addr;
    logic [31:0]       own_wdata;
    logic [3:0]        own_wstrb;
    logic              done;
    logic              timeout_fire;
    logic              grant_ready;
    logic [31:0]       grant_data;

    assign busy = (state == BUSY);

    always_comb begin
        own_valid = m0_valid;
        own_instr = m0_instr;
        own_addr  = m0_addr;
        own_wdata = m0_wdata;
        own_wstrb = m0_wstrb;
        if (owner) begin
            own_valid = m1_valid;
            own_instr = 1'b0;
            own_addr  = m1_addr;
            own_wdata = m1_wdata;
            own_wstrb = m1_wstrb;
        end
    end

    // A real slave completion always beats the watchdog in the same cycle.
    assign done         = busy && own_valid && s_ready;
    assign timeout_fire = WDOG_EN && busy && own_valid && !s_ready && (wdog == WDOG_LAST);
    assign grant_ready  = done || timeout_fire;
    assign grant_data   = timeout_fire ? TIMEOUT_DATA : s_rdata;

    always_comb begin
        s_valid = 1'b0;
        s_instr = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;
        if (busy) begin
            s_valid = own_valid && !timeout_fire;
            s_instr = own_instr;
            s_addr  = own_addr;
            s_wdata = own_wdata;
            s_wstrb = own_wstrb;
        end
    end

    always_comb begin
        m0_ready = grant_ready && !owner;
        m1_ready = grant_ready && owner;
        m0_rdata = m0_ready ? grant_data : '0;
        m1_rdata = m1_ready ? grant_data : '0;
    end

    always_comb begin
        state_next = state;
        owner_next = owner;
        prio_next  = prio;
        wdog_next  = wdog;
        case (state)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    owner_next = (m0_valid && m1_valid) ? prio : m1_valid;
                    state_next = BUSY;
                    wdog_next  = '0;
                end
            end
            BUSY: begin
                if (wdog != WDOG_MAX) begin
                    wdog_next = wdog + WDOG_W'(1);
                end
                // An aborting master leaves priority alone so it cannot skip its turn.
                if (!own_valid) begin
                    state_next = IDLE;
                end else if (grant_ready) begin
                    prio_next  = ~owner;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            owner <= 1'b0;
            prio  <= RESET_PRIO;
            wdog  <= '0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            prio  <= prio_next;
            wdog  <= wdog_next;
        end
    end

    // Only the first timeout since the last clear keeps its address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_err  <= 1'b0;
            timeout_addr <= '0;
        end else if (err_clr) begin
            timeout_err  <= 1'b0;
            timeout_addr <= '0;
        end else if (timeout_fire) begin
            timeout_err <= 1'b1;
            if (!timeout_err) begin
                timeout_addr <= own_addr;
            end
        end
    end

endmodule
